// File: rtl/reset_sequencer_if.sv
// Board-side reset signals of the reset sequencer: button/watchdog inputs
// and the staged reset outputs toward the CPU and peripherals.
interface reset_sequencer_if;
  logic       BUTTON_N_IN;
  logic       WDT_EN_IN;
  logic       WDT_KICK_IN;
  logic       PERIPH_RESET;
  logic       RESET;
  logic       HALT;
  logic       RUN;
  logic [1:0] CAUSE;

  // Board side: drives the button and watchdog, observes the reset pins
  modport master (
    output BUTTON_N_IN,
    output WDT_EN_IN,
    output WDT_KICK_IN,
    input  PERIPH_RESET,
    input  RESET,
    input  HALT,
    input  RUN,
    input  CAUSE
  );

  // Sequencer side
  modport slave (
    input  BUTTON_N_IN,
    input  WDT_EN_IN,
    input  WDT_KICK_IN,
    output PERIPH_RESET,
    output RESET,
    output HALT,
    output RUN,
    output CAUSE
  );
endinterface

// File: rtl/reset_sequencer.sv
// Central reset controller for the 68000 board: holds all resets after a
// trigger, releases peripherals first, then CPU RESET/HALT, then RUN.
// Triggers are a debounced front-panel press or a watchdog timeout.
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES     = 100000,
  parameter int unsigned STAGGER_CYCLES  = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned WDT_CYCLES      = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                MCLK_IN,
  input  logic                RESET_ALL_IN,
  reset_sequencer_if.slave    bus
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [1:0] CAUSE_POR    = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_WDT    = 2'd2;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUNNING = 2'd2
  } state_t;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_btn_db;
  logic [DB_W-1:0] r_db_cnt;

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_wdt_cnt;
  logic            r_periph;
  logic            r_cpu_rst;
  logic            r_run;
  logic [1:0]      r_cause;

  state_t          w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_wdt_nxt;
  logic            w_periph_nxt;
  logic            w_cpu_rst_nxt;
  logic            w_run_nxt;
  logic [1:0]      w_cause_nxt;

  logic            w_db_expire;
  logic            w_press;
  logic            w_wdt_to;

  // Two-flop synchroniser for the asynchronous push button
  always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
    if (RESET_ALL_IN) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.BUTTON_N_IN;
      r_sync2 <= r_sync1;
    end
  end

  // A level change is accepted once it has been stable long enough;
  // the press is flagged in the cycle the debounced level is about to fall
  assign w_db_expire = (r_sync2 != r_btn_db) && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign w_press     = w_db_expire && !r_sync2;

  // Debounce counter and debounced button level
  always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
    if (RESET_ALL_IN) begin
      r_btn_db <= 1'b1;
      r_db_cnt <= '0;
    end else if (r_sync2 == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (w_db_expire) begin
      r_btn_db <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // A kick in the expiry cycle suppresses the timeout
  assign w_wdt_to = (r_state == ST_RUNNING) && bus.WDT_EN_IN && !bus.WDT_KICK_IN &&
                    (r_wdt_cnt == CNT_W'(WDT_CYCLES - 1));

  // State, counters and registered outputs
  always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
    if (RESET_ALL_IN) begin
      r_state   <= ST_HOLD;
      r_cnt     <= '0;
      r_wdt_cnt <= '0;
      r_periph  <= 1'b1;
      r_cpu_rst <= 1'b1;
      r_run     <= 1'b0;
      r_cause   <= CAUSE_POR;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wdt_cnt <= w_wdt_nxt;
      r_periph  <= w_periph_nxt;
      r_cpu_rst <= w_cpu_rst_nxt;
      r_run     <= w_run_nxt;
      r_cause   <= w_cause_nxt;
    end
  end

  // Next-state, counter and output decode; triggers override the sequence
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wdt_nxt     = '0;
    w_periph_nxt  = r_periph;
    w_cpu_rst_nxt = r_cpu_rst;
    w_run_nxt     = r_run;
    w_cause_nxt   = r_cause;

    case (r_state)
      ST_HOLD: begin
        w_periph_nxt  = 1'b1;
        w_cpu_rst_nxt = 1'b1;
        w_run_nxt     = 1'b0;
        // Count is frozen while the button is still held down
        if (r_btn_db) begin
          if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            w_state_nxt  = ST_STAGGER;
            w_cnt_nxt    = '0;
            w_periph_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_STAGGER: begin
        if (r_cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
          w_state_nxt   = ST_RUNNING;
          w_cnt_nxt     = '0;
          w_cpu_rst_nxt = 1'b0;
          w_run_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUNNING: begin
        if (bus.WDT_EN_IN && !bus.WDT_KICK_IN && !w_wdt_to) begin
          w_wdt_nxt = r_wdt_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_HOLD;
        w_cnt_nxt     = '0;
        w_periph_nxt  = 1'b1;
        w_cpu_rst_nxt = 1'b1;
        w_run_nxt     = 1'b0;
      end
    endcase

    // Button press wins over a simultaneous watchdog timeout
    if (w_press || w_wdt_to) begin
      w_state_nxt   = ST_HOLD;
      w_cnt_nxt     = '0;
      w_wdt_nxt     = '0;
      w_periph_nxt  = 1'b1;
      w_cpu_rst_nxt = 1'b1;
      w_run_nxt     = 1'b0;
      w_cause_nxt   = w_press ? CAUSE_BUTTON : CAUSE_WDT;
    end
  end

  assign bus.PERIPH_RESET = r_periph;
  assign bus.RESET        = r_cpu_rst;
  assign bus.HALT         = r_cpu_rst;
  assign bus.RUN          = r_run;
  assign bus.CAUSE        = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with HOLD=8, STAGGER=4, DEBOUNCE=3, WDT=20.
module tb_reset_sequencer;

  logic clk;
  logic rst;
  int   tests;
  int   failed;
  logic run_ok;

  reset_sequencer_if bus ();

  reset_sequencer #(
    .HOLD_CYCLES     (8),
    .STAGGER_CYCLES  (4),
    .DEBOUNCE_CYCLES (3),
    .WDT_CYCLES      (20),
    .CNT_W           (20)
  ) dut (
    .MCLK_IN      (clk),
    .RESET_ALL_IN (rst),
    .bus          (bus)
  );

  localparam logic [3:0] O_HOLD = 4'b1110;  // {PERIPH_RESET, RESET, HALT, RUN}
  localparam logic [3:0] O_STAG = 4'b0110;
  localparam logic [3:0] O_RUN  = 4'b0001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {bus.PERIPH_RESET, bus.RESET, bus.HALT, bus.RUN};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    run_ok = 1'b1;
    rst    = 1'b0;
    bus.BUTTON_N_IN = 1'b1;
    bus.WDT_EN_IN   = 1'b0;
    bus.WDT_KICK_IN = 1'b0;
    #2 rst = 1'b1;
    ticks(2);
    chk("reset_outs", outs(), O_HOLD);
    chk("reset_cause", {2'b00, bus.CAUSE}, 4'd0);

    // 1: power-on sequence, edges counted from reset release
    rst = 1'b0;
    ticks(7);
    chk("por_hold_e7", outs(), O_HOLD);
    ticks(1);
    chk("por_stag_e8", outs(), O_STAG);
    ticks(3);
    chk("por_stag_e11", outs(), O_STAG);
    ticks(1);
    chk("por_run_e12", outs(), O_RUN);
    chk("por_cause", {2'b00, bus.CAUSE}, 4'd0);

    // 2: short glitch ignored, 6-cycle press triggers at edge 5
    bus.BUTTON_N_IN = 1'b0;
    ticks(2);
    bus.BUTTON_N_IN = 1'b1;
    ticks(10);
    chk("glitch_run", outs(), O_RUN);
    bus.BUTTON_N_IN = 1'b0;
    ticks(4);
    chk("press_e4_run", outs(), O_RUN);
    ticks(1);
    chk("press_e5_hold", outs(), O_HOLD);
    chk("press_cause", {2'b00, bus.CAUSE}, 4'd1);
    ticks(1);
    bus.BUTTON_N_IN = 1'b1;
    // release: debounce rises at R5, hold counts from R6, stagger at R13
    ticks(12);
    chk("press_rel_hold", outs(), O_HOLD);
    ticks(1);
    chk("press_rel_stag", outs(), O_STAG);
    ticks(4);
    chk("press_rel_run", outs(), O_RUN);
    chk("press_rel_cause", {2'b00, bus.CAUSE}, 4'd1);

    // 3: long hold freezes the hold counter
    bus.BUTTON_N_IN = 1'b0;
    ticks(5);
    chk("long_press_hold", outs(), O_HOLD);
    ticks(45);
    chk("long_press_frozen", outs(), O_HOLD);
    bus.BUTTON_N_IN = 1'b1;
    ticks(12);
    chk("long_rel_hold", outs(), O_HOLD);
    ticks(1);
    chk("long_rel_stag", outs(), O_STAG);
    ticks(4);
    chk("long_rel_run", outs(), O_RUN);

    // 4: watchdog fires 20 cycles after enabling in RUNNING
    bus.WDT_EN_IN = 1'b1;
    ticks(19);
    chk("wdt_e19_run", outs(), O_RUN);
    ticks(1);
    chk("wdt_e20_hold", outs(), O_HOLD);
    chk("wdt_cause", {2'b00, bus.CAUSE}, 4'd2);
    ticks(7);
    chk("wdt_seq_hold", outs(), O_HOLD);
    ticks(1);
    chk("wdt_seq_stag", outs(), O_STAG);
    ticks(4);
    chk("wdt_seq_run", outs(), O_RUN);
    for (int i = 1; i <= 200; i++) begin
      bus.WDT_KICK_IN = ((i % 15) == 0);
      ticks(1);
      if (!bus.RUN) run_ok = 1'b0;
    end
    bus.WDT_KICK_IN = 1'b0;
    chk("wdt_kicked_run", {3'b000, run_ok}, 4'd1);
    chk("wdt_kicked_cause", {2'b00, bus.CAUSE}, 4'd2);

    // 5: kick in the expiry cycle, then press coinciding with timeout
    bus.WDT_EN_IN = 1'b0;
    ticks(1);
    bus.WDT_EN_IN = 1'b1;
    ticks(19);
    bus.WDT_KICK_IN = 1'b1;
    ticks(1);
    bus.WDT_KICK_IN = 1'b0;
    chk("kick_expiry_run", outs(), O_RUN);
    ticks(15);
    bus.BUTTON_N_IN = 1'b0;
    ticks(4);
    chk("coincide_e19_run", outs(), O_RUN);
    ticks(1);
    chk("coincide_hold", outs(), O_HOLD);
    chk("coincide_cause", {2'b00, bus.CAUSE}, 4'd1);
    bus.BUTTON_N_IN = 1'b1;
    bus.WDT_EN_IN   = 1'b0;
    ticks(13);
    chk("pre_async_stag", outs(), O_STAG);

    // 6: asynchronous master reset during STAGGER, then full restart
    #2 rst = 1'b1;
    #1;
    chk("async_outs", outs(), O_HOLD);
    chk("async_cause", {2'b00, bus.CAUSE}, 4'd0);
    ticks(1);
    rst = 1'b0;
    ticks(7);
    chk("restart_hold_e7", outs(), O_HOLD);
    ticks(1);
    chk("restart_stag_e8", outs(), O_STAG);
    ticks(4);
    chk("restart_run_e12", outs(), O_RUN);
    chk("restart_cause", {2'b00, bus.CAUSE}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
